// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the next-PC sequencer.
//   pc_seq_state_t  front-end FSM state (IDLE, RUN, STALL, HALT)
//   redirect_src_t  redirect source (NONE, EXC, BR, JMP)
//   src_rank()      priority of a redirect source, larger wins
// Optional feature macro used by the sequencer: PC_SEQ_BOUNDS_CHECK_EN.
package pc_pkg;

  localparam int DATA_WIDTH = 27;
  localparam logic [DATA_WIDTH-1:0] PC_STEP      = 27'd1;
  localparam logic [DATA_WIDTH-1:0] RESET_VECTOR = 27'd0;
  localparam logic [DATA_WIDTH-1:0] EXC_VECTOR   = 27'h0000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_seq_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EXC  = 2'd1,
    BR   = 2'd2,
    JMP  = 2'd3
  } redirect_src_t;

  // Exception beats branch beats jump beats nothing.
  function automatic logic [1:0] src_rank(input redirect_src_t src);
    case (src)
      EXC:     src_rank = 2'd3;
      BR:      src_rank = 2'd2;
      JMP:     src_rank = 2'd1;
      default: src_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: priority select between live redirect requests and a
// pending redirect held across pipeline stalls.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   i_exc, i_exc_target      exception request and handler address
//   i_br_valid, i_br_target  taken-branch request and target
//   i_jmp_valid, i_jmp_target jump request and target
//   i_capture                store the winning request as pending
//   i_clear                  drop the pending request (wins over capture)
//   o_src, o_target          winning source/target among live and pending
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = pc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_exc,
  input  logic [DATA_WIDTH-1:0] i_exc_target,
  input  logic                  i_br_valid,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic                  i_jmp_valid,
  input  logic [DATA_WIDTH-1:0] i_jmp_target,
  input  logic                  i_capture,
  input  logic                  i_clear,
  output redirect_src_t         o_src,
  output logic [DATA_WIDTH-1:0] o_target
);

  redirect_src_t         live_src;
  logic [DATA_WIDTH-1:0] live_target;
  redirect_src_t         pend_src;
  logic [DATA_WIDTH-1:0] pend_target;

  always_comb begin
    live_src    = NONE;
    live_target = '0;
    if (i_exc) begin
      live_src    = EXC;
      live_target = i_exc_target;
    end else if (i_br_valid) begin
      live_src    = BR;
      live_target = i_br_target;
    end else if (i_jmp_valid) begin
      live_src    = JMP;
      live_target = i_jmp_target;
    end
  end

  // On equal rank the live request is newer, so it replaces the pending one.
  always_comb begin
    o_src    = live_src;
    o_target = live_target;
    if (src_rank(pend_src) > src_rank(live_src)) begin
      o_src    = pend_src;
      o_target = pend_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_src    <= NONE;
      pend_target <= '0;
    end else if (i_clear) begin
      pend_src    <= NONE;
      pend_target <= '0;
    end else if (i_capture) begin
      pend_src    <= o_src;
      pend_target <= o_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the program counter register.
// Arbitrates sequential advance, branch/jump redirect and exception vector,
// and sequences the front end through IDLE/RUN/STALL/HALT.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_start           leave IDLE/HALT and begin fetching
//   i_pc              current PC register value
//   i_fetch_ready     fetch unit accepts the current fetch address
//   i_stall           hold the PC
//   i_br_valid/target taken-branch redirect
//   i_jmp_valid/target jump redirect
//   i_exc             exception request
//   i_halt            halt instruction retired
//   o_pc_load/o_pc_next  PC register load enable and value
//   o_fetch_valid     i_pc is a valid fetch address
//   o_flush           one-cycle pulse after any redirect load
//   o_state           FSM state for debug
//   o_fault           bounds fault pulse
// Optional feature: define PC_SEQ_BOUNDS_CHECK_EN to redirect any load at or
// above PC_LIMIT to the exception vector and pulse o_fault; otherwise o_fault
// is tied low.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = pc_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PC_STEP      = DATA_WIDTH'(pc_pkg::PC_STEP),
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(pc_pkg::RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(pc_pkg::EXC_VECTOR)
`ifdef PC_SEQ_BOUNDS_CHECK_EN
  ,
  parameter logic [DATA_WIDTH-1:0] PC_LIMIT     = DATA_WIDTH'(27'h4000000)
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_fetch_ready,
  input  logic                  i_stall,
  input  logic                  i_br_valid,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic                  i_jmp_valid,
  input  logic [DATA_WIDTH-1:0] i_jmp_target,
  input  logic                  i_exc,
  input  logic                  i_halt,
  output logic                  o_pc_load,
  output logic [DATA_WIDTH-1:0] o_pc_next,
  output logic                  o_fetch_valid,
  output logic                  o_flush,
  output logic [1:0]            o_state,
  output logic                  o_fault
);

  pc_seq_state_t         state;
  pc_seq_state_t         nxt_state;
  redirect_src_t         arb_src;
  logic [DATA_WIDTH-1:0] arb_target;
  logic                  capture;
  logic                  clear;
  logic                  redirect_taken;
  logic                  raw_load;
  logic [DATA_WIDTH-1:0] raw_next;
  logic [DATA_WIDTH-1:0] pc_inc;

  assign pc_inc = i_pc + PC_STEP;

  pc_redirect_arb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .i_exc        (i_exc),
    .i_exc_target (EXC_VECTOR),
    .i_br_valid   (i_br_valid),
    .i_br_target  (i_br_target),
    .i_jmp_valid  (i_jmp_valid),
    .i_jmp_target (i_jmp_target),
    .i_capture    (capture),
    .i_clear      (clear),
    .o_src        (arb_src),
    .o_target     (arb_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      o_flush <= 1'b0;
    end else begin
      state   <= nxt_state;
      o_flush <= redirect_taken;
    end
  end

  // Exceptions cut through a stall; other redirects wait in the arbiter's
  // pending slot until the stall drops, and halt yields to any redirect.
  always_comb begin
    nxt_state      = state;
    raw_load       = 1'b0;
    raw_next       = '0;
    o_fetch_valid  = 1'b0;
    capture        = 1'b0;
    clear          = 1'b0;
    redirect_taken = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          raw_load  = 1'b1;
          raw_next  = RESET_VECTOR;
          nxt_state = RUN;
        end
      end
      RUN: begin
        o_fetch_valid = 1'b1;
        if (arb_src == EXC) begin
          raw_load       = 1'b1;
          raw_next       = arb_target;
          clear          = 1'b1;
          redirect_taken = 1'b1;
        end else if (i_stall) begin
          capture   = 1'b1;
          nxt_state = STALL;
        end else if (arb_src != NONE) begin
          raw_load       = 1'b1;
          raw_next       = arb_target;
          clear          = 1'b1;
          redirect_taken = 1'b1;
        end else if (i_halt) begin
          nxt_state = HALT;
        end else begin
          raw_load = i_fetch_ready;
          raw_next = pc_inc;
        end
      end
      STALL: begin
        if (arb_src == EXC) begin
          raw_load       = 1'b1;
          raw_next       = arb_target;
          clear          = 1'b1;
          redirect_taken = 1'b1;
          nxt_state      = RUN;
        end else if (i_stall) begin
          capture = 1'b1;
        end else begin
          nxt_state = RUN;
          if (arb_src != NONE) begin
            raw_load       = 1'b1;
            raw_next       = arb_target;
            clear          = 1'b1;
            redirect_taken = 1'b1;
          end
        end
      end
      HALT: begin
        if (i_start) begin
          nxt_state = RUN;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign o_pc_load = raw_load;
  assign o_state   = state;

`ifdef PC_SEQ_BOUNDS_CHECK_EN
  logic bounds_hit;

  assign bounds_hit = raw_load && (raw_next >= PC_LIMIT);
  assign o_pc_next  = bounds_hit ? EXC_VECTOR : raw_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_fault <= 1'b0;
    end else begin
      o_fault <= bounds_hit;
    end
  end
`else
  assign o_pc_next = raw_next;
  assign o_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// A local PC register loads o_pc_next on o_pc_load and feeds i_pc back,
// with an override used to place the PC at the top of the address space.
// Honours PC_SEQ_BOUNDS_CHECK_EN for the bounds-fault section.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [26:0] i_pc;
  logic        i_fetch_ready;
  logic        i_stall;
  logic        i_br_valid;
  logic [26:0] i_br_target;
  logic        i_jmp_valid;
  logic [26:0] i_jmp_target;
  logic        i_exc;
  logic        i_halt;
  logic        o_pc_load;
  logic [26:0] o_pc_next;
  logic        o_fetch_valid;
  logic        o_flush;
  logic [1:0]  o_state;
  logic        o_fault;

  logic [26:0] pc_reg;
  logic        pc_force_en;
  logic [26:0] pc_force_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= '0;
    else if (o_pc_load) pc_reg <= o_pc_next;
  end

  assign i_pc = pc_force_en ? pc_force_val : pc_reg;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_pc          (i_pc),
    .i_fetch_ready (i_fetch_ready),
    .i_stall       (i_stall),
    .i_br_valid    (i_br_valid),
    .i_br_target   (i_br_target),
    .i_jmp_valid   (i_jmp_valid),
    .i_jmp_target  (i_jmp_target),
    .i_exc         (i_exc),
    .i_halt        (i_halt),
    .o_pc_load     (o_pc_load),
    .o_pc_next     (o_pc_next),
    .o_fetch_valid (o_fetch_valid),
    .o_flush       (o_flush),
    .o_state       (o_state),
    .o_fault       (o_fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, then settle before checks.
  task automatic applyStimulus(input logic start, input logic stall,
                               input logic br, input logic [26:0] br_t,
                               input logic jmp, input logic [26:0] jmp_t,
                               input logic exc, input logic halt);
    i_start      = start;
    i_stall      = stall;
    i_br_valid   = br;
    i_br_target  = br_t;
    i_jmp_valid  = jmp;
    i_jmp_target = jmp_t;
    i_exc        = exc;
    i_halt       = halt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] pc_sequencer directed test");
    reset         = 1'b1;
    pc_force_en   = 1'b0;
    pc_force_val  = '0;
    i_fetch_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_state", 32'(o_state), 32'd0);
    checkOutput("rst_load", 32'(o_pc_load), 32'd0);
    checkOutput("rst_next", 32'(o_pc_next), 32'd0);
    checkOutput("rst_fvalid", 32'(o_fetch_valid), 32'd0);
    checkOutput("rst_flush", 32'(o_flush), 32'd0);
    checkOutput("rst_fault", 32'(o_fault), 32'd0);
    reset = 1'b0;

    // Start: load reset vector, then advance sequentially.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("start_load", 32'(o_pc_load), 32'd1);
    checkOutput("start_next", 32'(o_pc_next), 32'd0);
    tick();
    i_fetch_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_state", 32'(o_state), 32'd1);
    checkOutput("run_fvalid", 32'(o_fetch_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("seq_pc", 32'(pc_reg), 32'(k));
      checkOutput("seq_next", 32'(o_pc_next), 32'(k + 1));
      checkOutput("seq_load", 32'(o_pc_load), 32'd1);
      tick();
    end
    checkOutput("pc5", 32'(pc_reg), 32'd5);

    // Branch and jump together: branch wins.
    applyStimulus(0, 0, 1, 27'h100, 1, 27'h200, 0, 0);
    checkOutput("br_load", 32'(o_pc_load), 32'd1);
    checkOutput("br_next", 32'(o_pc_next), 32'h100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("br_flush", 32'(o_flush), 32'd1);
    checkOutput("br_pc", 32'(pc_reg), 32'h100);
    checkOutput("br_seq", 32'(o_pc_next), 32'h101);
    tick();
    checkOutput("br_flush_end", 32'(o_flush), 32'd0);
    checkOutput("br_pc2", 32'(pc_reg), 32'h101);

    // Three stall cycles, jump arrives in the second one.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("st1_load", 32'(o_pc_load), 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 1, 27'h40, 0, 0);
    checkOutput("st2_state", 32'(o_state), 32'd2);
    checkOutput("st2_load", 32'(o_pc_load), 32'd0);
    checkOutput("st2_fvalid", 32'(o_fetch_valid), 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("st3_load", 32'(o_pc_load), 32'd0);
    checkOutput("st3_pc", 32'(pc_reg), 32'h101);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rel_load", 32'(o_pc_load), 32'd1);
    checkOutput("rel_next", 32'(o_pc_next), 32'h40);
    tick();
    checkOutput("rel_pc", 32'(pc_reg), 32'h40);
    checkOutput("rel_state", 32'(o_state), 32'd1);
    checkOutput("rel_flush", 32'(o_flush), 32'd1);
    checkOutput("rel_seq", 32'(o_pc_next), 32'h41);
    tick();

    // Exception during stall discards a pending branch.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 27'h300, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("exc_load", 32'(o_pc_load), 32'd1);
    checkOutput("exc_next", 32'(o_pc_next), 32'h10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exc_state", 32'(o_state), 32'd1);
    checkOutput("exc_pc", 32'(pc_reg), 32'h10);
    checkOutput("exc_nopend", 32'(o_pc_next), 32'h11);
    tick();

    // Wrap at the top of the address space.
    pc_force_val = 27'h7FFFFFF;
    pc_force_en  = 1'b1;
    #1;
    checkOutput("wrap_next", 32'(o_pc_next), 32'd0);
    checkOutput("wrap_load", 32'(o_pc_load), 32'd1);
    tick();
    checkOutput("wrap_fault", 32'(o_fault), 32'd0);
`ifdef PC_SEQ_BOUNDS_CHECK_EN
    pc_force_val = 27'h3FFFFFF;
    #1;
    checkOutput("bnd_next", 32'(o_pc_next), 32'h10);
    tick();
    checkOutput("bnd_fault", 32'(o_fault), 32'd1);
    pc_force_en = 1'b0;
    #1;
    tick();
    checkOutput("bnd_fault_end", 32'(o_fault), 32'd0);
`else
    pc_force_en = 1'b0;
    #1;
`endif

    // Halt at 0x20, hold for five cycles, then resume without a load.
    applyStimulus(0, 0, 0, 0, 1, 27'h20, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("halt_pc", 32'(pc_reg), 32'h20);
    checkOutput("halt_load", 32'(o_pc_load), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("halt_state", 32'(o_state), 32'd3);
      checkOutput("halt_hold", 32'(o_pc_load), 32'd0);
      checkOutput("halt_fvalid", 32'(o_fetch_valid), 32'd0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resume_load", 32'(o_pc_load), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resume_state", 32'(o_state), 32'd1);
    checkOutput("resume_pc", 32'(pc_reg), 32'h20);
    checkOutput("resume_next", 32'(o_pc_next), 32'h21);
    tick();

    // Exception and halt together: exception wins, stay in RUN.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("exch_next", 32'(o_pc_next), 32'h10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("exch_state", 32'(o_state), 32'd1);
    checkOutput("exch_pc", 32'(pc_reg), 32'h10);

    // Branch with stall is held; a later lower-priority jump does not replace it.
    applyStimulus(0, 1, 1, 27'h50, 0, 0, 0, 0);
    checkOutput("pend_load", 32'(o_pc_load), 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 1, 27'h60, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_next", 32'(o_pc_next), 32'h50);
    tick();
    checkOutput("pend_pc", 32'(pc_reg), 32'h50);

    // Fetch not ready: no sequential load.
    i_fetch_ready = 1'b0;
    #1;
    checkOutput("nordy_load", 32'(o_pc_load), 32'd0);
    checkOutput("nordy_next", 32'(o_pc_next), 32'h51);
    i_fetch_ready = 1'b1;

    // Reset mid-run clears the flush pulse and returns to IDLE.
    applyStimulus(0, 0, 1, 27'h70, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_flush", 32'(o_flush), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_state", 32'(o_state), 32'd0);
    checkOutput("mid_rst_flush", 32'(o_flush), 32'd0);
    checkOutput("mid_rst_load", 32'(o_pc_load), 32'd0);
    checkOutput("mid_rst_next", 32'(o_pc_next), 32'd0);
    checkOutput("mid_rst_fvalid", 32'(o_fetch_valid), 32'd0);
    checkOutput("mid_rst_fault", 32'(o_fault), 32'd0);
    checkOutput("mid_rst_pc", 32'(pc_reg), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 27-bit program counter register.
- Each cycle it arbitrates between sequential advance, branch redirect, jump redirect and exception vector.
- Drives the PC register's load enable and next value, and handshakes with instruction fetch.
- Sits between decode/execute redirect sources and the PC register. Owns run/stall/halt sequencing of the front end.

Parameters:
- DATA_WIDTH, 27, PC width in bits.
- PC_STEP, 1, sequential increment (word-addressed).
- RESET_VECTOR, 0, PC loaded on leaving IDLE.
- EXC_VECTOR, 27'h0000010, exception handler address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_start  in  1  leave IDLE/HALT, begin fetching
- i_pc  in  DATA_WIDTH  current PC register value
- i_fetch_ready  in  1  fetch unit accepts o_fetch_valid this cycle
- i_stall  in  1  pipeline stall, hold PC
- i_br_valid  in  1  taken-branch redirect request
- i_br_target  in  DATA_WIDTH  branch target
- i_jmp_valid  in  1  jump redirect request
- i_jmp_target  in  DATA_WIDTH  jump target
- i_exc  in  1  exception request
- i_halt  in  1  halt instruction retired
- o_pc_load  out  1  load enable to PC register
- o_pc_next  out  DATA_WIDTH  value to load
- o_fetch_valid  out  1  i_pc is a valid fetch address
- o_flush  out  1  one-cycle pulse on any redirect
- o_state  out  2  FSM state, for debug
- o_fault  out  1  bounds fault (optional feature only; else tied 0)

Behaviour:
- Clock/reset: reset is asynchronous, active-high; clock is clk. All state registers are reset asynchronously.
- Reset values: state=IDLE, pending redirect cleared, o_flush=0, o_fault=0.
- Combinational outputs o_pc_load, o_pc_next, o_fetch_valid are 0 in IDLE and HALT.
- States:
  - IDLE=0: i_start -> o_pc_load=1, o_pc_next=RESET_VECTOR, go to RUN next cycle.
  - RUN=1: o_fetch_valid=1.
  - STALL=2: o_fetch_valid=0, o_pc_load=0.
  - HALT=3: i_start -> go to RUN without a PC load; execution resumes at the held PC.
- Redirect priority in RUN, highest first: i_exc > i_br_valid > i_jmp_valid > sequential.
  - Redirect: o_pc_load=1 and o_pc_next=target, regardless of i_fetch_ready. Registered o_flush=1 the following cycle.
  - Sequential: o_pc_load=i_fetch_ready && !i_stall, o_pc_next=(i_pc+PC_STEP) mod 2^DATA_WIDTH. 27'h7FFFFFF wraps to 0 with no flag.
- Stall handling:
  - i_stall in RUN with no redirect -> STALL. STALL -> RUN when i_stall deasserts.
  - A redirect arriving during stall, or together with i_stall in RUN, is captured in a pending register (highest priority wins; a later higher-priority request overwrites it).
  - The pending redirect is applied, and the register cleared, on the first cycle i_stall is low. Redirects are never lost.
- Exceptions override stall: i_exc in RUN or STALL loads EXC_VECTOR immediately, clears pending, and enters RUN.
- Halt: i_halt in RUN -> HALT, no load that cycle. If i_halt and i_exc coincide, i_exc wins and the state stays RUN.
- Latency: PC register reflects o_pc_next one clock after o_pc_load.
- Reset mid-operation clears pending and state; the PC register resets independently to 0.

Optional Feature:
- Macro: PC_SEQ_BOUNDS_CHECK_EN
- Enabled: adds parameter PC_LIMIT (default 27'h4000000). Any o_pc_next >= PC_LIMIT, for sequential or redirect loads, is replaced by EXC_VECTOR. o_fault is registered and pulses for 1 cycle.
- Disabled: no comparison; o_fault is constant 0.

Decomposition:
- Shared package pc_pkg holds:
  - state enum pc_seq_state_t {IDLE, RUN, STALL, HALT}
  - redirect-source enum {NONE, EXC, BR, JMP}
  - DATA_WIDTH, RESET_VECTOR and EXC_VECTOR constants
- One natural sub-module: pc_redirect_arb, a combinational priority select plus the pending-redirect register. The FSM stays in the top module.

Test Plan:
- Reset, then i_start, then i_fetch_ready=1 for 4 cycles -> PC sequence 0,1,2,3,4; o_state=RUN.
- At PC=5, i_br_valid=1 with target 27'h100 and i_jmp_valid=1 with target 27'h200 together -> o_pc_next=27'h100; o_flush high the next cycle; next PC 27'h101.
- i_stall=1 for 3 cycles while i_jmp_valid pulses to target 27'h40 in stall cycle 2 -> no load during stall; PC=27'h40 one cycle after stall release.
- i_exc during STALL -> immediate load of 27'h10; state RUN; pending redirect discarded.
- Force i_pc=27'h7FFFFFF in RUN -> o_pc_next=0. With PC_SEQ_BOUNDS_CHECK_EN and PC_LIMIT=27'h100, PC 27'hFF advancing -> o_pc_next=27'h10 and o_fault pulses.
- i_halt at PC=27'h20 -> HALT, o_pc_load=0 for 5 cycles; i_start -> RUN, fetch resumes at 27'h20. Reset asserted mid-RUN -> IDLE, all outputs 0.
